instr_fetch_buffer: RTL
=======================

# instr_fetch_buffer

- Fetch stage directly upstream of the instruction decoder.
- Issues 128-bit line requests (two 64-bit instructions) to the instruction memory port and unpacks the responses into an in-order instruction FIFO.
- Presents one instruction word plus its PC per cycle to the decoder over a valid/ready handshake.
- Handles branch redirects: flushes buffered instructions, discards in-flight stale responses, and skips the upper/lower slot on unaligned targets.

## Interface
- PC_W, 32, program counter width; bits [2:0] are always zero in emitted PCs
- DEPTH, 8, instruction FIFO entries; power of two, ≥4
- MAX_OUT, 2, maximum outstanding memory requests, 1..4
- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- redirect_valid  in  1  load new fetch PC and flush, single-cycle pulse
- redirect_pc  in  PC_W  target PC; bits [2:0] ignored (treated as 0)
- req_valid  out  1  memory line request valid
- req_ready  in  1  memory accepts request
- req_addr  out  PC_W  16-byte-aligned line address, bits [3:0]=0
- resp_valid  in  1  response data valid; in order, no backpressure
- resp_data  in  128  [63:0] = instr at line+0, [127:64] = instr at line+8
- instr_valid  out  1  instr/instr_pc valid to decoder
- instr_ready  in  1  decoder accepts
- instr  out  64  instruction word (opcode in [63:54])
- instr_pc  out  PC_W  PC of instr

## Operation
**State**
- fetch_pc: next line to request.
- out_pc: PC of the FIFO head.
- FIFO count.
- outstanding count, 0..MAX_OUT.
- drop_cnt: stale responses still to discard.
- skip shift register, MAX_OUT bits: one skip flag per outstanding request, consumed in order.

**Requests**
- req_valid = !rst_state && outstanding < MAX_OUT && (DEPTH − count − 2·(outstanding − drop_cnt)) ≥ 2.
- The FIFO space for every live response is reserved in advance, so overflow is impossible.
- req_addr = fetch_pc with bits [3:0] cleared.
- On a request fire: fetch_pc += 16, outstanding++, push a skip flag. The flag is 1 only for the first request after a redirect whose redirect_pc[3] = 1.

**Responses**
- A response pops the oldest skip flag and decrements outstanding.
- If drop_cnt > 0: discard the response and decrement drop_cnt.
- Otherwise, with skip = 1: write resp_data[127:64] only (1 entry).
- Otherwise: write [63:0] then [127:64] (2 entries, lower slot first).

**Output**
- instr and instr_valid come from the FIFO head.
- Pop on instr_valid && instr_ready, then out_pc += 8.

**Redirect** (priority over everything in the same cycle)
- count ← 0.
- out_pc ← fetch_pc ← {redirect_pc[PC_W−1:3], 3'b0}.
- drop_cnt ← outstanding + req_fire − resp_fire, counting all in-flight requests, including any accepted this cycle. A response arriving in the redirect cycle is discarded.
- The skip flag for the next request is set from redirect_pc[3].
- A decoder pop in the redirect cycle is allowed. That instruction was already sampled and is considered consumed.

**Arithmetic**
- PCs wrap modulo 2^PC_W.
- FIFO pointers are log2(DEPTH) bits with wrap; count is log2(DEPTH)+1 bits.

## Timing
**Reset values**
- req_valid = 0, instr_valid = 0.
- req_addr = 0, instr_pc = 0, instr = 0.
- Counters zero, fetch_pc = out_pc = 0.
- After reset, fetch waits for the first redirect. req_valid stays 0 until a redirect has been seen (rst_state flag).

**Latency**
- Redirect cycle N → req_valid may assert in N+1.
- resp_valid in cycle M → instr_valid in M+1.

**Throughput**
- One instruction per cycle sustained when memory answers at least one line per 2 cycles.

**Handshakes**
- req_valid and req_addr hold stable while req_ready = 0, unless a redirect occurs. A redirect may change req_addr the following cycle.

**Simultaneous events**
- FIFO: a push of 2 and a pop of 1 in the same cycle is legal. Count updates by +2−1.
- Outstanding counter: a request fire and a response in the same cycle leave outstanding unchanged.
- Skip register: a request fire and a response in the same cycle do a shift and an insert at the correct position.

**Reset mid-operation**
- All state clears; in-flight responses after reset are not discarded via drop_cnt.
- The memory side must also be reset, so resp_valid = 0 after rst.

## Structure
- Shared package fetch_pkg:
  - INSTR_W = 64, LINE_W = 128, LINE_BYTES = 16, INSTR_BYTES = 8.
  - Typedefs instr_t and line_t, shared with the decoder.
- One sub-module, fetch_fifo:
  - 2-write/1-read, parameterized DEPTH.
  - Ports: wr_en[1:0], wr_data0/1, rd_en, rd_data, count, flush.
- Request, credit and drop logic stays in the top level.

## Test plan
- **Aligned stream:** redirect 0x1000; memory answers each line in 1 cycle with data = address-tagged words → decoder sees PCs 0x1000, 0x1008, 0x1010… with matching words, no gaps after the pipeline fills.
- **Unaligned target:** redirect 0x2008 → first req_addr 0x2000; the first instruction delivered is resp_data[127:64] with instr_pc 0x2008; the next is 0x2010.
- **Backpressure:** instr_ready = 0 for 20 cycles → count saturates at DEPTH, req_valid drops, no entry lost or duplicated; resume yields the contiguous PC sequence.
- **Redirect with 2 outstanding:** both responses are discarded (drop_cnt 2→0); the first delivered instruction has the new target PC; no stale data reaches instr_valid.
- **Redirect in the same cycle as resp_valid and req fire:** the response is discarded, the accepted request is counted stale, and the first valid output is the redirect target.
- **Reset mid-stream:** rst high for 1 cycle with FIFO half full → next cycle instr_valid = 0, req_valid = 0, count 0, and req_valid stays 0 until the next redirect.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared fetch/decode types: instruction word and memory line widths.
package fetch_pkg;
  localparam int INSTR_W     = 64;
  localparam int LINE_W      = 128;
  localparam int LINE_BYTES  = 16;
  localparam int INSTR_BYTES = 8;

  typedef logic [INSTR_W-1:0] instr_t;
  typedef logic [LINE_W-1:0]  line_t;
endpackage

// File: rtl/fetch_fifo.sv
// In-order instruction FIFO: up to two writes and one read per cycle.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic [1:0]  wr_en,
  input  instr_t      wr_data0,
  input  instr_t      wr_data1,
  input  logic        rd_en,
  output instr_t      rd_data,
  output logic [AW:0] count
);
  logic [AW-1:0] wptr, rptr;
  instr_t        mem [DEPTH];
  logic [1:0]    nwr;
  logic          rd_ok;

  assign nwr     = {1'b0, wr_en[0]} + {1'b0, wr_en[1]};
  assign rd_ok   = rd_en && (count != '0);
  assign rd_data = (count != '0) ? mem[rptr] : '0;

  // A lone upper-slot write lands at wptr, so slot 1 is offset only when slot 0 is written too.
  always_ff @(posedge clk) begin
    if (wr_en[0]) mem[wptr] <= wr_data0;
    if (wr_en[1]) mem[wptr + AW'(wr_en[0])] <= wr_data1;
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      wptr  <= wptr + AW'(nwr);
      rptr  <= rptr + AW'(rd_ok);
      count <= count + (AW+1)'(nwr) - (AW+1)'(rd_ok);
    end
  end
endmodule

// File: rtl/instr_fetch_buffer.sv
// Fetch stage: issues line requests, unpacks responses into the instruction FIFO, handles redirects.
module instr_fetch_buffer
  import fetch_pkg::*;
#(
  parameter int PC_W    = 32,
  parameter int DEPTH   = 8,
  parameter int MAX_OUT = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            redirect_valid,
  input  logic [PC_W-1:0] redirect_pc,
  output logic            req_valid,
  input  logic            req_ready,
  output logic [PC_W-1:0] req_addr,
  input  logic            resp_valid,
  input  line_t           resp_data,
  output logic            instr_valid,
  input  logic            instr_ready,
  output instr_t          instr,
  output logic [PC_W-1:0] instr_pc
);
  localparam int AW = $clog2(DEPTH);
  localparam int OW = $clog2(MAX_OUT + 1);

  logic               started;
  logic [PC_W-1:0]    fetch_pc, out_pc, redir_pc;
  logic [OW-1:0]      outstanding, drop_cnt, in_flight;
  logic [MAX_OUT-1:0] skip_sr, skip_ins;
  logic               skip_next;
  logic [AW:0]        count;
  logic [31:0]        reserved;
  logic               req_fire, resp_fire, pop;
  logic [1:0]         wr_en;
  instr_t             rd_data;

  // Every live (non-stale) request already owns two FIFO slots.
  assign reserved    = 32'(count) + 32'(outstanding - drop_cnt) * 2;
  assign req_valid   = started && (32'(outstanding) < 32'(MAX_OUT)) &&
                       (reserved + 32'd2 <= 32'(DEPTH));
  assign req_addr    = {fetch_pc[PC_W-1:4], 4'b0};
  assign req_fire    = req_valid && req_ready;
  assign resp_fire   = resp_valid && (outstanding != '0);
  assign instr_valid = (count != '0);
  assign instr       = rd_data;
  assign instr_pc    = out_pc;
  assign pop         = instr_valid && instr_ready;
  assign redir_pc    = {redirect_pc[PC_W-1:3], 3'b0};
  assign in_flight   = outstanding + OW'(req_fire) - OW'(resp_fire);

  always_comb begin
    wr_en = 2'b00;
    if (resp_fire && !redirect_valid && drop_cnt == '0)
      wr_en = skip_sr[0] ? 2'b10 : 2'b11;
  end

  // Oldest flag sits at bit 0; a new flag goes just above the survivors.
  always_comb begin
    skip_ins = resp_fire ? (skip_sr >> 1) : skip_sr;
    if (req_fire)
      for (int i = 0; i < MAX_OUT; i++)
        if (i == int'(outstanding) - int'(resp_fire)) skip_ins[i] = skip_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      started     <= 1'b0;
      fetch_pc    <= '0;
      out_pc      <= '0;
      outstanding <= '0;
      drop_cnt    <= '0;
      skip_sr     <= '0;
      skip_next   <= 1'b0;
    end else begin
      outstanding <= in_flight;
      skip_sr     <= skip_ins;
      if (redirect_valid) begin
        started   <= 1'b1;
        fetch_pc  <= redir_pc;
        out_pc    <= redir_pc;
        drop_cnt  <= in_flight;
        skip_next <= redirect_pc[3];
      end else begin
        if (req_fire) begin
          fetch_pc  <= fetch_pc + PC_W'(LINE_BYTES);
          skip_next <= 1'b0;
        end
        if (pop) out_pc <= out_pc + PC_W'(INSTR_BYTES);
        if (resp_fire && drop_cnt != '0) drop_cnt <= drop_cnt - OW'(1);
      end
    end
  end

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .flush    (redirect_valid),
    .wr_en    (wr_en),
    .wr_data0 (resp_data[63:0]),
    .wr_data1 (resp_data[127:64]),
    .rd_en    (pop),
    .rd_data  (rd_data),
    .count    (count)
  );
endmodule
